// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/load-store ports, the arbiter and the synchronous RAM.
// Handshake: a requester raises req with its address/data and holds it until the matching
// ack pulses for one cycle; anything still high at the next edge is a new request.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_rdata;
  logic              i_ack;

  logic              d_req;
  logic              d_we;
  logic [3:0]        d_wmask;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ack;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              busy;
  logic [1:0]        dbg_state;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_wmask, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
           busy, dbg_state
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_wmask, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
           busy, dbg_state
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and load/store ports onto one single-port RAM, sequencing each
// access through IDLE -> ACCESS -> RESP and returning data with a one-cycle ack.
module mem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter bit PRIO_DATA = 1'b0
) (
  input  logic          CLK,
  input  logic          RESET,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              grant_data_q, grant_data_d;
  logic              store_q, store_d;
  logic              last_data_q, last_data_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              pick_data;

  // Data wins if alone, if it has fixed priority, or if fetch was granted last.
  assign pick_data = bus.d_req & (~bus.i_req | PRIO_DATA | ~last_data_q);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      grant_data_q <= 1'b0;
      store_q      <= 1'b0;
      last_data_q  <= 1'b0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_data_q <= grant_data_d;
      store_q      <= store_d;
      last_data_q  <= last_data_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.i_req || bus.d_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_data_d = grant_data_q;
    store_d      = store_q;
    last_data_d  = last_data_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = '0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          grant_data_d = pick_data;
          last_data_d  = pick_data;
          store_d      = pick_data & bus.d_we;
          mem_en_d     = 1'b1;
          mem_addr_d   = pick_data ? bus.d_addr : bus.i_addr;
          mem_we_d     = (pick_data && bus.d_we) ? bus.d_wmask : 4'b0000;
          mem_wdata_d  = bus.d_wdata;
        end
      end
      ACCESS: ;
      RESP: begin
        // RAM output is valid now, one cycle after the strobe.
        if (grant_data_q) begin
          d_ack_d = 1'b1;
          if (!store_q) d_rdata_d = bus.mem_rdata;
        end else begin
          i_ack_d   = 1'b1;
          i_rdata_d = bus.mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance with a RAM model, plus a
// data-priority instance used for the starvation scenario.
module tb_mem_arbiter;

  logic CLK;
  logic RESET;
  int   n_tests;
  int   n_fail;

  logic        poke_en;
  logic [7:0]  poke_addr;
  logic [31:0] poke_data;
  logic [31:0] ram [256];

  logic [0:0] exp_a[$];
  logic [0:0] exp_b[$];
  int         b_i_acks;

  mem_arbiter_if #(.ADDR_W(8)) bus_a ();
  mem_arbiter_if #(.ADDR_W(8)) bus_b ();

  mem_arbiter #(.ADDR_W(8), .PRIO_DATA(1'b0)) dut_a (.CLK(CLK), .RESET(RESET), .bus(bus_a));
  mem_arbiter #(.ADDR_W(8), .PRIO_DATA(1'b1)) dut_b (.CLK(CLK), .RESET(RESET), .bus(bus_b));

  assign bus_b.mem_rdata = '0;

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // synchronous RAM model with registered read and a backdoor load port
  always @(posedge CLK) begin
    if (poke_en) begin
      ram[poke_addr] <= poke_data;
    end else if (bus_a.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus_a.mem_we[b]) ram[bus_a.mem_addr][8*b +: 8] <= bus_a.mem_wdata[8*b +: 8];
      bus_a.mem_rdata <= ram[bus_a.mem_addr];
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic poke(input logic [7:0] addr, input logic [31:0] data);
    poke_en   = 1'b1;
    poke_addr = addr;
    poke_data = data;
    tick();
    poke_en   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    b_i_acks = 0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    bus_a.i_req = 1'b1; bus_a.i_addr = '0;
    bus_a.d_req = 1'b1; bus_a.d_we = 1'b0; bus_a.d_wmask = '0; bus_a.d_addr = '0; bus_a.d_wdata = '0;
    bus_b.i_req = 1'b0; bus_b.i_addr = '0;
    bus_b.d_req = 1'b0; bus_b.d_we = 1'b0; bus_b.d_wmask = '0; bus_b.d_addr = '0; bus_b.d_wdata = '0;

    // 1: reset held two cycles with both requests high
    RESET = 1'b1;
    tick();
    tick();
    chk("rst_i_ack", bus_a.i_ack, 0);
    chk("rst_d_ack", bus_a.d_ack, 0);
    chk("rst_mem_en", bus_a.mem_en, 0);
    chk("rst_mem_we", bus_a.mem_we, 0);
    chk("rst_i_rdata", bus_a.i_rdata, 0);
    chk("rst_d_rdata", bus_a.d_rdata, 0);
    chk("rst_mem_addr", bus_a.mem_addr, 0);
    chk("rst_mem_wdata", bus_a.mem_wdata, 0);
    chk("rst_busy", bus_a.busy, 0);
    bus_a.i_req = 1'b0;
    bus_a.d_req = 1'b0;
    RESET = 1'b0;
    poke(8'd5, 32'h0010_0093);
    poke(8'd2, 32'hDEAD_BEEF);
    poke(8'd3, 32'h1122_3344);

    // 2: single fetch
    bus_a.i_addr = 8'd5;
    bus_a.i_req  = 1'b1;
    tick();
    chk("f_mem_en", bus_a.mem_en, 1);
    chk("f_mem_we", bus_a.mem_we, 0);
    chk("f_mem_addr", bus_a.mem_addr, 5);
    chk("f_busy", bus_a.busy, 1);
    chk("f_state_access", bus_a.dbg_state, 1);
    tick();
    chk("f_mem_en_off", bus_a.mem_en, 0);
    chk("f_no_early_ack", bus_a.i_ack, 0);
    tick();
    chk("f_i_ack", bus_a.i_ack, 1);
    chk("f_i_rdata", bus_a.i_rdata, 32'h0010_0093);
    chk("f_busy_ack", bus_a.busy, 0);
    bus_a.i_req = 1'b0;
    tick();
    chk("f_ack_pulse", bus_a.i_ack, 0);
    chk("f_no_regrant", bus_a.mem_en, 0);

    // 3: collision after reset, data first; renewed data request then loses to fetch
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    bus_a.i_addr = 8'd5; bus_a.i_req = 1'b1;
    bus_a.d_addr = 8'd2; bus_a.d_we = 1'b0; bus_a.d_req = 1'b1;
    tick();
    chk("c1_grant_data", bus_a.mem_addr, 2);
    tick();
    tick();
    chk("c1_d_ack", bus_a.d_ack, 1);
    chk("c1_d_rdata", bus_a.d_rdata, 32'hDEAD_BEEF);
    chk("c1_no_i_ack", bus_a.i_ack, 0);
    bus_a.d_addr = 8'd3;
    tick();
    chk("c2_grant_fetch", bus_a.mem_addr, 5);
    chk("c2_d_ack_pulse", bus_a.d_ack, 0);
    tick();
    tick();
    chk("c2_i_ack", bus_a.i_ack, 1);
    chk("c2_i_rdata", bus_a.i_rdata, 32'h0010_0093);
    chk("c2_no_d_ack", bus_a.d_ack, 0);
    bus_a.i_req = 1'b0;
    tick();
    chk("c3_grant_data", bus_a.mem_addr, 3);
    tick();
    tick();
    chk("c3_d_ack", bus_a.d_ack, 1);
    chk("c3_d_rdata", bus_a.d_rdata, 32'h1122_3344);
    bus_a.d_req = 1'b0;

    // 4: partial store, then reload; late input changes must be ignored
    bus_a.d_addr = 8'd3; bus_a.d_we = 1'b1; bus_a.d_wmask = 4'b0011;
    bus_a.d_wdata = 32'hAABB_CCDD; bus_a.d_req = 1'b1;
    tick();
    chk("s_mem_en", bus_a.mem_en, 1);
    chk("s_mem_we", bus_a.mem_we, 4'b0011);
    chk("s_mem_wdata", bus_a.mem_wdata, 32'hAABB_CCDD);
    bus_a.d_wdata = 32'h0; bus_a.d_wmask = 4'b1111;
    tick();
    chk("s_mem_we_off", bus_a.mem_we, 0);
    tick();
    chk("s_d_ack", bus_a.d_ack, 1);
    chk("s_d_rdata_kept", bus_a.d_rdata, 32'h1122_3344);
    bus_a.d_we = 1'b0;
    tick();
    tick();
    tick();
    chk("s_reload_ack", bus_a.d_ack, 1);
    chk("s_reload_data", bus_a.d_rdata, 32'h1122_CCDD);
    bus_a.d_we = 1'b1; bus_a.d_wmask = 4'b0000; bus_a.d_wdata = 32'hFFFF_FFFF;
    tick();
    chk("z_mem_en", bus_a.mem_en, 1);
    chk("z_mem_we", bus_a.mem_we, 0);
    tick();
    tick();
    chk("z_d_ack", bus_a.d_ack, 1);
    bus_a.d_we = 1'b0;
    tick();
    tick();
    tick();
    chk("z_reload_data", bus_a.d_rdata, 32'h1122_CCDD);
    bus_a.d_req = 1'b0;

    // 5: reset in ACCESS drops the request silently
    bus_a.i_addr = 8'd5; bus_a.i_req = 1'b1;
    tick();
    chk("r_in_access", bus_a.dbg_state, 1);
    RESET = 1'b1;
    tick();
    chk("r_busy", bus_a.busy, 0);
    chk("r_mem_en", bus_a.mem_en, 0);
    RESET = 1'b0;
    bus_a.i_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("r_no_ack", bus_a.i_ack, 0);
    end

    // 6: both ports hold requests continuously on both instances
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    exp_a = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_b = '{1'b1, 1'b1, 1'b1, 1'b1};
    bus_a.i_req = 1'b1; bus_a.d_req = 1'b1; bus_a.d_we = 1'b0;
    bus_b.i_req = 1'b1; bus_b.d_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus_a.d_ack || bus_a.i_ack) begin
        if (exp_a.size() == 0) chk("rr_extra_ack", 1, 0);
        else chk("rr_order", bus_a.d_ack, exp_a.pop_front());
      end
      if (bus_b.d_ack || bus_b.i_ack) begin
        if (bus_b.i_ack) b_i_acks++;
        if (exp_b.size() == 0) chk("pd_extra_ack", 1, 0);
        else chk("pd_order", bus_b.d_ack, exp_b.pop_front());
      end
    end
    chk("rr_all_acks", exp_a.size(), 0);
    chk("pd_all_acks", exp_b.size(), 0);
    chk("pd_fetch_starved", b_i_acks, 0);
    bus_a.i_req = 1'b0; bus_a.d_req = 1'b0;
    bus_b.i_req = 1'b0; bus_b.d_req = 1'b0;
    tick();

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
